fpga_mmio_gen2: RTL and testbench
=================================

Name: fpga_mmio_gen2

Overview:
Parametrised memory-mapped I/O control-register block for board peripherals: 7-segment digits, LEDs, switches and buttons. It sits on the fabric-to-core (F2C) request/response interface at the core's MMIO window. Over the single-board fixed-width version it adds:
- configurable peripheral counts
- input synchronisation and debouncing
- sticky button-press capture with write-1-to-clear
- a free-running cycle counter

Parameters:
NUM_SEG7, 6, number of 7-segment digits (1..8)
NUM_LED, 10, LED count (1..32)
NUM_SW, 10, switch count (1..32)
NUM_BTN, 2, button count (1..32)
DEBOUNCE_CYC, 16, stable cycles required before a synced input level is accepted (>=2)
SEG7_RST, 7'h7F, reset/idle value of every digit (all segments off, active-low)

Ports:
CLK_50  in  1  clock
RstQnnnL  in  1  reset; one clock; reset is asynchronous and active-low
F2C_ReqValidQ502H  in  1  request valid
F2C_ReqOpcodeQ502H  in  t_opcode  RD or WR; other opcodes ignored
F2C_ReqAddressQ502H  in  32  byte address; bits [19:0] decoded
F2C_ReqDataQ502H  in  32  write data
F2C_RspValidQ500H  out  1  response valid
F2C_RspOpcodeQ500H  out  t_opcode  always RD_RSP
F2C_RspAddressQ500H  out  32  echoed request address
F2C_RspDataQ500H  out  32  read data; 0 for writes
Button  in  NUM_BTN  raw asynchronous buttons
Switch  in  NUM_SW  raw asynchronous switches
SEG7  out  NUM_SEG7*7  digit i on bits [7i+6:7i]
LED  out  NUM_LED  LED drive

Behaviour:
- Reset values:
  - every SEG7 digit = SEG7_RST; LED = 0; all response outputs = 0
  - debounce counters 0; stable levels 0; edge sticky 0; cycle counter 0
- Address map (offsets in [19:0]):
  - 0x000+4i: SEG7_i, RW, i<NUM_SEG7, data[6:0]
  - 0x040: LED, RW, data[NUM_LED-1:0]
  - 0x044: SWITCH, RO, debounced level
  - 0x048: BUTTON, RO, debounced level
  - 0x04C: BTN_EDGE, W1C sticky rising-edge flags
  - 0x050: CYCLE_CNT, RO, 32-bit
- Unmapped offsets, and SEG7 indices >= NUM_SEG7: writes have no effect; reads return 0; a response is still issued.
- Pipeline:
  - Q502 request sampled into Q503; decode, register write and read mux in Q503.
  - Response registered to Q504, then Q500.
  - Fixed latency: request at cycle N gives response valid at N+3, for both RD and WR. One request per cycle, back-to-back allowed, no stall.
- Read data:
  - A read returns the register value before any write in the same cycle. Only one request can occur per cycle, so no RAW hazard exists.
  - Upper unused bits are zero.
- RW register write takes effect on the cycle after Q503; SEG7/LED outputs are driven directly from the registers.
- Debounce, per Switch/Button bit:
  - 2-FF synchroniser.
  - Counter increments while synced != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1, stable <= synced and the counter clears.
  - Input-to-register latency is 2+DEBOUNCE_CYC cycles. A glitch shorter than DEBOUNCE_CYC cycles never changes stable.
- BTN_EDGE:
  - A bit sets on a stable 0->1 of its button.
  - A WR with data bit=1 clears it; bit=0 leaves it.
  - Set and clear in the same cycle: set wins.
- CYCLE_CNT increments every cycle and wraps 0xFFFFFFFF->0. Writes are ignored.
- Reset mid-operation: in-flight requests are dropped and no response is issued for them.

Optional Feature:
Macro FPGA_MMIO_HEX_DECODE_EN.
- Defined:
  - Adds 0x058 SEG7_HEX (RW, 32-bit, nibble i drives digit i) and 0x05C CTRL (RW, bit0 HEX_MODE, reset 0).
  - HEX_MODE=1: digit i output = hex-to-7seg(active-low) of nibble i; SEG7_i registers are retained but not displayed.
  - HEX_MODE=0: raw SEG7_i registers are displayed.
- Undefined: 0x058/0x05C are unmapped (read 0) and no decoder logic is present.

Decomposition:
- Package lotr_pkg gets:
  - offset constants CR_MMIO2_SEG7_BASE, CR_MMIO2_LED, CR_MMIO2_SWITCH, CR_MMIO2_BUTTON, CR_MMIO2_BTN_EDGE, CR_MMIO2_CYCLE_CNT, CR_MMIO2_SEG7_HEX, CR_MMIO2_CTRL
  - a hex-to-7seg function
- Reuse the existing t_opcode.
- One sub-module, mmio_debounce (params: WIDTH, DEBOUNCE_CYC), instantiated once for Switch and once for Button.

Test Plan:
- WR 0x040 data 0x3FF at cycle N -> RspValid at N+3, RspData 0, Address echoed 0x40; LED=0x3FF from N+2; subsequent RD 0x040 returns 0x3FF.
- Back-to-back WR 0x000 data 0x12, RD 0x000, RD 0x0A0 (unmapped) -> three consecutive responses with data 0, 0x12, 0; SEG7[6:0]=0x12.
- Switch[3] pulse of 5 cycles (DEBOUNCE_CYC=16) -> SWITCH reads 0. Held 30 cycles -> SWITCH reads 0x8 after 18 cycles.
- Button[1] stable press -> BTN_EDGE reads 0x2. WR 0x04C data 0x1 -> still 0x2. WR 0x2 -> 0. New edge coinciding with the clear -> bit stays 1.
- Preload by running 2^32-2 cycles (or force the counter to 0xFFFFFFFE) -> RD CYCLE_CNT shows wrap to 0; WR to 0x050 has no effect.
- Assert RstQnnnL low with a RD in flight -> no response; SEG7 all 0x7F, LED 0. With FPGA_MMIO_HEX_DECODE_EN: WR 0x05C=1, WR 0x058=0x00000008 -> digit0 = 7'h00.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared types and constants for the board MMIO register block.
// Latency: n/a (types, offsets and a pure combinational helper only).
// Backpressure: n/a.
package lotr_pkg;

    // Fabric-to-core request/response opcodes
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        RD     = 2'd1,
        WR     = 2'd2,
        RD_RSP = 2'd3
    } t_opcode;

    // Register offsets inside the MMIO window (address bits [19:0])
    localparam logic [19:0] CR_MMIO2_SEG7_BASE = 20'h00000;
    localparam logic [19:0] CR_MMIO2_LED       = 20'h00040;
    localparam logic [19:0] CR_MMIO2_SWITCH    = 20'h00044;
    localparam logic [19:0] CR_MMIO2_BUTTON    = 20'h00048;
    localparam logic [19:0] CR_MMIO2_BTN_EDGE  = 20'h0004C;
    localparam logic [19:0] CR_MMIO2_CYCLE_CNT = 20'h00050;
    localparam logic [19:0] CR_MMIO2_SEG7_HEX  = 20'h00058;
    localparam logic [19:0] CR_MMIO2_CTRL      = 20'h0005C;

    // Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// Per-bit 2-FF synchroniser plus stability-counter debouncer with a rising-edge pulse.
// Latency: 2+DEBOUNCE_CYC cycles from a raw level change to the stable output.
// Backpressure: none; free-running, samples every cycle.
module mmio_debounce #(
    parameter int WIDTH        = 1,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_out
);

    // Counter only needs to reach DEBOUNCE_CYC-1, which fits in clog2 bits
    localparam int            CW       = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Count consecutive disagreeing cycles; accept the synced level on the last one
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchroniser, counters and accepted levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stable_out = stable_q;
    assign rise_out   = rise_d;

endmodule

// File: rtl/fpga_mmio_gen2.sv
// Board MMIO registers (7-seg, LEDs, switches, buttons, cycle counter); FPGA_MMIO_HEX_DECODE_EN adds hex display mode.
// Latency: fixed 3 cycles request-to-response for RD and WR; register writes visible 2 cycles after the request.
// Backpressure: none; one request per cycle accepted back-to-back, never stalls.
module fpga_mmio_gen2
    import lotr_pkg::*;
#(
    parameter int         NUM_SEG7     = 6,
    parameter int         NUM_LED      = 10,
    parameter int         NUM_SW       = 10,
    parameter int         NUM_BTN      = 2,
    parameter int         DEBOUNCE_CYC = 16,
    parameter logic [6:0] SEG7_RST     = 7'h7F
) (
    input  logic                    CLK_50,
    input  logic                    RstQnnnL,
    input  logic                    F2C_ReqValidQ502H,
    input  t_opcode                 F2C_ReqOpcodeQ502H,
    input  logic [31:0]             F2C_ReqAddressQ502H,
    input  logic [31:0]             F2C_ReqDataQ502H,
    output logic                    F2C_RspValidQ500H,
    output t_opcode                 F2C_RspOpcodeQ500H,
    output logic [31:0]             F2C_RspAddressQ500H,
    output logic [31:0]             F2C_RspDataQ500H,
    input  logic [NUM_BTN-1:0]      Button,
    input  logic [NUM_SW-1:0]       Switch,
    output logic [NUM_SEG7*7-1:0]   SEG7,
    output logic [NUM_LED-1:0]      LED
);

    // Q503 request stage
    logic        req_vld_q, req_vld_d;
    logic        req_wr_q, req_wr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_data_q, req_data_d;

    // Architectural registers
    logic [NUM_SEG7*7-1:0] seg7_q, seg7_d;
    logic [NUM_LED-1:0]    led_q, led_d;
    logic [NUM_BTN-1:0]    btn_edge_q, btn_edge_d;
    logic [31:0]           cycle_cnt_q, cycle_cnt_d;

    // Response pipeline
    logic        rsp504_vld_q, rsp504_vld_d;
    logic [31:0] rsp504_addr_q, rsp504_addr_d;
    logic [31:0] rsp504_data_q, rsp504_data_d;
    logic        rsp500_vld_q, rsp500_vld_d;
    t_opcode     rsp500_op_q, rsp500_op_d;
    logic [31:0] rsp500_addr_q, rsp500_addr_d;
    logic [31:0] rsp500_data_q, rsp500_data_d;

    // Debounced inputs
    logic [NUM_SW-1:0]  sw_stable;
    logic [NUM_SW-1:0]  unused_sw_rise;
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_rise;

    // Decode helpers
    logic [19:0] off;
    logic [2:0]  seg_idx;
    logic        seg_hit;
    logic        wr_en;
    logic [31:0] rd_data;
    logic [NUM_SEG7*7-1:0] seg7_out;
    logic        unused_data;

    mmio_debounce #(.WIDTH(NUM_SW), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_deb (
        .clk        (CLK_50),
        .rst_n      (RstQnnnL),
        .raw_in     (Switch),
        .stable_out (sw_stable),
        .rise_out   (unused_sw_rise)
    );

    mmio_debounce #(.WIDTH(NUM_BTN), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_deb (
        .clk        (CLK_50),
        .rst_n      (RstQnnnL),
        .raw_in     (Button),
        .stable_out (btn_stable),
        .rise_out   (btn_rise)
    );

    // Accept only RD/WR; everything else produces no response
    always_comb begin
        req_vld_d  = F2C_ReqValidQ502H &&
                     (F2C_ReqOpcodeQ502H == RD || F2C_ReqOpcodeQ502H == WR);
        req_wr_d   = (F2C_ReqOpcodeQ502H == WR);
        req_addr_d = F2C_ReqAddressQ502H;
        req_data_d = F2C_ReqDataQ502H;
    end

    // Address decode for the Q503 request; only word-aligned SEG7 slots that exist hit
    always_comb begin
        off     = req_addr_q[19:0];
        seg_idx = off[4:2];
        seg_hit = (off[19:5] == 15'd0) && (off[1:0] == 2'd0) && (int'(seg_idx) < NUM_SEG7);
        wr_en   = req_vld_q && req_wr_q;
    end

    // Register writes; a fresh debounced edge beats a same-cycle W1C clear
    always_comb begin
        seg7_d      = seg7_q;
        led_d       = led_q;
        btn_edge_d  = btn_edge_q | btn_rise;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (wr_en) begin
            if (seg_hit) begin
                for (int i = 0; i < NUM_SEG7; i++) begin
                    if (int'(seg_idx) == i) seg7_d[7*i +: 7] = req_data_q[6:0];
                end
            end
            if (off == CR_MMIO2_LED) led_d = req_data_q[NUM_LED-1:0];
            if (off == CR_MMIO2_BTN_EDGE)
                btn_edge_d = (btn_edge_q & ~req_data_q[NUM_BTN-1:0]) | btn_rise;
        end
    end

`ifdef FPGA_MMIO_HEX_DECODE_EN
    logic [31:0] seg7_hex_q, seg7_hex_d;
    logic        hex_mode_q, hex_mode_d;

    // Hex-mode register writes
    always_comb begin
        seg7_hex_d = seg7_hex_q;
        hex_mode_d = hex_mode_q;
        if (wr_en && off == CR_MMIO2_SEG7_HEX) seg7_hex_d = req_data_q;
        if (wr_en && off == CR_MMIO2_CTRL)     hex_mode_d = req_data_q[0];
    end

    // Hex-mode state
    always_ff @(posedge CLK_50 or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            seg7_hex_q <= '0;
            hex_mode_q <= 1'b0;
        end else begin
            seg7_hex_q <= seg7_hex_d;
            hex_mode_q <= hex_mode_d;
        end
    end

    // Digits show decoded nibbles in hex mode, raw registers otherwise
    always_comb begin
        seg7_out = seg7_q;
        if (hex_mode_q) begin
            for (int i = 0; i < NUM_SEG7; i++)
                seg7_out[7*i +: 7] = hex_to_seg7(seg7_hex_q[4*i +: 4]);
        end
    end
`else
    assign seg7_out = seg7_q;
`endif

    // Read mux sees pre-write register values; unused upper bits stay zero
    always_comb begin
        rd_data = '0;
        if (seg_hit) begin
            for (int i = 0; i < NUM_SEG7; i++) begin
                if (int'(seg_idx) == i) rd_data[6:0] = seg7_q[7*i +: 7];
            end
        end
        case (off)
            CR_MMIO2_LED:       rd_data[NUM_LED-1:0] = led_q;
            CR_MMIO2_SWITCH:    rd_data[NUM_SW-1:0]  = sw_stable;
            CR_MMIO2_BUTTON:    rd_data[NUM_BTN-1:0] = btn_stable;
            CR_MMIO2_BTN_EDGE:  rd_data[NUM_BTN-1:0] = btn_edge_q;
            CR_MMIO2_CYCLE_CNT: rd_data              = cycle_cnt_q;
`ifdef FPGA_MMIO_HEX_DECODE_EN
            CR_MMIO2_SEG7_HEX:  rd_data              = seg7_hex_q;
            CR_MMIO2_CTRL:      rd_data[0]           = hex_mode_q;
`endif
            default: ;
        endcase
    end

    // Response staging: Q503 -> Q504 -> Q500; writes return zero data
    always_comb begin
        rsp504_vld_d  = req_vld_q;
        rsp504_addr_d = req_vld_q ? req_addr_q : 32'd0;
        rsp504_data_d = (req_vld_q && !req_wr_q) ? rd_data : 32'd0;
        rsp500_vld_d  = rsp504_vld_q;
        rsp500_op_d   = rsp504_vld_q ? RD_RSP : OP_NOP;
        rsp500_addr_d = rsp504_addr_q;
        rsp500_data_d = rsp504_data_q;
    end

    // All pipeline and register state; reset drops any in-flight request
    always_ff @(posedge CLK_50 or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            req_vld_q     <= 1'b0;
            req_wr_q      <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            seg7_q        <= {NUM_SEG7{SEG7_RST}};
            led_q         <= '0;
            btn_edge_q    <= '0;
            cycle_cnt_q   <= '0;
            rsp504_vld_q  <= 1'b0;
            rsp504_addr_q <= '0;
            rsp504_data_q <= '0;
            rsp500_vld_q  <= 1'b0;
            rsp500_op_q   <= OP_NOP;
            rsp500_addr_q <= '0;
            rsp500_data_q <= '0;
        end else begin
            req_vld_q     <= req_vld_d;
            req_wr_q      <= req_wr_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            seg7_q        <= seg7_d;
            led_q         <= led_d;
            btn_edge_q    <= btn_edge_d;
            cycle_cnt_q   <= cycle_cnt_d;
            rsp504_vld_q  <= rsp504_vld_d;
            rsp504_addr_q <= rsp504_addr_d;
            rsp504_data_q <= rsp504_data_d;
            rsp500_vld_q  <= rsp500_vld_d;
            rsp500_op_q   <= rsp500_op_d;
            rsp500_addr_q <= rsp500_addr_d;
            rsp500_data_q <= rsp500_data_d;
        end
    end

    // Write data bits beyond the widest field are intentionally ignored
    assign unused_data = ^req_data_q;

    assign F2C_RspValidQ500H   = rsp500_vld_q;
    assign F2C_RspOpcodeQ500H  = rsp500_op_q;
    assign F2C_RspAddressQ500H = rsp500_addr_q;
    assign F2C_RspDataQ500H    = rsp500_data_q;
    assign SEG7                = seg7_out;
    assign LED                 = led_q;

endmodule

// File: tb/tb_fpga_mmio_gen2.sv
// Directed bench for fpga_mmio_gen2 with default parameters.
// Responses are captured by a monitor; checks compare against hand-computed values.
// No backpressure exists on the interface, so requests are driven freely.
module tb_fpga_mmio_gen2;
    import lotr_pkg::*;

    localparam int NUM_SEG7 = 6;
    localparam int NUM_LED  = 10;
    localparam int NUM_SW   = 10;
    localparam int NUM_BTN  = 2;
    localparam int DEB      = 16;

    logic                  CLK_50 = 1'b0;
    logic                  RstQnnnL = 1'b0;
    logic                  F2C_ReqValidQ502H = 1'b0;
    t_opcode               F2C_ReqOpcodeQ502H = OP_NOP;
    logic [31:0]           F2C_ReqAddressQ502H = '0;
    logic [31:0]           F2C_ReqDataQ502H = '0;
    logic                  F2C_RspValidQ500H;
    t_opcode               F2C_RspOpcodeQ500H;
    logic [31:0]           F2C_RspAddressQ500H;
    logic [31:0]           F2C_RspDataQ500H;
    logic [NUM_BTN-1:0]    Button = '0;
    logic [NUM_SW-1:0]     Switch = '0;
    logic [NUM_SEG7*7-1:0] SEG7;
    logic [NUM_LED-1:0]    LED;

    fpga_mmio_gen2 #(
        .NUM_SEG7(NUM_SEG7), .NUM_LED(NUM_LED), .NUM_SW(NUM_SW),
        .NUM_BTN(NUM_BTN), .DEBOUNCE_CYC(DEB), .SEG7_RST(7'h7F)
    ) dut (
        .CLK_50              (CLK_50),
        .RstQnnnL            (RstQnnnL),
        .F2C_ReqValidQ502H   (F2C_ReqValidQ502H),
        .F2C_ReqOpcodeQ502H  (F2C_ReqOpcodeQ502H),
        .F2C_ReqAddressQ502H (F2C_ReqAddressQ502H),
        .F2C_ReqDataQ502H    (F2C_ReqDataQ502H),
        .F2C_RspValidQ500H   (F2C_RspValidQ500H),
        .F2C_RspOpcodeQ500H  (F2C_RspOpcodeQ500H),
        .F2C_RspAddressQ500H (F2C_RspAddressQ500H),
        .F2C_RspDataQ500H    (F2C_RspDataQ500H),
        .Button              (Button),
        .Switch              (Switch),
        .SEG7                (SEG7),
        .LED                 (LED)
    );

    always #5 CLK_50 = ~CLK_50;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        t_opcode     op;
    } rsp_t;

    rsp_t rsp_q[$];
    int   req_cyc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge CLK_50) cyc <= cyc + 1;

    // Capture each response with the cycle it was presented in
    always @(posedge CLK_50) begin
        rsp_t r;
        #1;
        if (F2C_RspValidQ500H === 1'b1) begin
            r.cyc  = cyc;
            r.addr = F2C_RspAddressQ500H;
            r.data = F2C_RspDataQ500H;
            r.op   = F2C_RspOpcodeQ500H;
            rsp_q.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input t_opcode op, input logic [31:0] addr, input logic [31:0] data);
        F2C_ReqValidQ502H   = 1'b1;
        F2C_ReqOpcodeQ502H  = op;
        F2C_ReqAddressQ502H = addr;
        F2C_ReqDataQ502H    = data;
        req_cyc_q.push_back(cyc);
        @(negedge CLK_50);
        F2C_ReqValidQ502H   = 1'b0;
        F2C_ReqOpcodeQ502H  = OP_NOP;
    endtask

    task automatic get_rsp(input string tag, output rsp_t r);
        int w = 0;
        int rc;
        r.cyc = 0; r.addr = '0; r.data = '0; r.op = OP_NOP;
        while (rsp_q.size() == 0 && w < 12) begin
            @(negedge CLK_50);
            w++;
        end
        n_cmp++;
        assert (rsp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_timeout observed=none expected=response", tag);
        end
        if (rsp_q.size() != 0) begin
            r  = rsp_q.pop_front();
            rc = (req_cyc_q.size() != 0) ? req_cyc_q.pop_front() : 0;
            chk({tag, "_lat"}, 64'(r.cyc - rc), 64'd3);
            chk({tag, "_op"}, 64'(r.op), 64'(RD_RSP));
        end
    endtask

    task automatic do_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rsp_t r;
        req(RD, addr, 32'd0);
        get_rsp(tag, r);
        chk(tag, 64'(r.data), 64'(exp));
        chk({tag, "_addr"}, 64'(r.addr), 64'(addr));
    endtask

    task automatic do_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        rsp_t r;
        req(WR, addr, data);
        get_rsp(tag, r);
        chk({tag, "_data"}, 64'(r.data), 64'd0);
    endtask

    initial begin
        rsp_t r;
        int   n0;

        // Reset state
        repeat (3) @(negedge CLK_50);
        chk("rst_vld", 64'(F2C_RspValidQ500H), 64'd0);
        chk("rst_op", 64'(F2C_RspOpcodeQ500H), 64'd0);
        chk("rst_addr", 64'(F2C_RspAddressQ500H), 64'd0);
        chk("rst_data", 64'(F2C_RspDataQ500H), 64'd0);
        chk("rst_seg7", 64'(SEG7), 64'h3FF_FFFF_FFFF);
        chk("rst_led", 64'(LED), 64'd0);
        RstQnnnL = 1'b1;
        repeat (2) @(negedge CLK_50);

        // LED write: visible two cycles after request, response three
        n0 = cyc;
        req(WR, 32'h0000_0040, 32'h0000_03FF);
        chk("led_n1", 64'(LED), 64'd0);
        @(negedge CLK_50);
        chk("led_n2", 64'(LED), 64'h3FF);
        get_rsp("led_wr", r);
        chk("led_wr_cyc", 64'(r.cyc - n0), 64'd3);
        chk("led_wr_data", 64'(r.data), 64'd0);
        chk("led_wr_addr", 64'(r.addr), 64'h40);
        do_rd("led_rd", 32'h0000_0040, 32'h0000_03FF);

        // Back-to-back WR/RD/RD unmapped
        req(WR, 32'h0000_0000, 32'h0000_0012);
        req(RD, 32'h0000_0000, 32'd0);
        req(RD, 32'h0000_00A0, 32'd0);
        get_rsp("b2b0", r);
        n0 = r.cyc;
        chk("b2b0_data", 64'(r.data), 64'd0);
        get_rsp("b2b1", r);
        chk("b2b1_cyc", 64'(r.cyc - n0), 64'd1);
        chk("b2b1_data", 64'(r.data), 64'h12);
        get_rsp("b2b2", r);
        chk("b2b2_cyc", 64'(r.cyc - n0), 64'd2);
        chk("b2b2_data", 64'(r.data), 64'd0);
        chk("b2b2_addr", 64'(r.addr), 64'hA0);
        chk("seg7_d0", 64'(SEG7[6:0]), 64'h12);
        chk("seg7_d1", 64'(SEG7[13:7]), 64'h7F);
        do_wr("seg7_idx6_wr", 32'h0000_0018, 32'h0000_0055);
        do_rd("seg7_idx6_rd", 32'h0000_0018, 32'd0);
        do_wr("ro_sw_wr", 32'h0000_0044, 32'h0000_03FF);
        do_rd("ro_sw_rd", 32'h0000_0044, 32'd0);

        // Switch glitch rejected, held level accepted
        Switch[3] = 1'b1;
        repeat (5) @(negedge CLK_50);
        Switch[3] = 1'b0;
        repeat (30) @(negedge CLK_50);
        do_rd("sw_glitch", 32'h0000_0044, 32'd0);
        Switch[3] = 1'b1;
        repeat (10) @(negedge CLK_50);
        do_rd("sw_early", 32'h0000_0044, 32'd0);
        repeat (10) @(negedge CLK_50);
        do_rd("sw_held", 32'h0000_0044, 32'h0000_0008);
        Switch[3] = 1'b0;

        // Button edge capture and write-1-to-clear
        Button = 2'b10;
        repeat (25) @(negedge CLK_50);
        do_rd("btn_lvl", 32'h0000_0048, 32'h0000_0002);
        do_rd("btn_edge", 32'h0000_004C, 32'h0000_0002);
        do_wr("btn_w1c_b0", 32'h0000_004C, 32'h0000_0001);
        do_rd("btn_edge_kept", 32'h0000_004C, 32'h0000_0002);
        do_wr("btn_w1c_b1", 32'h0000_004C, 32'h0000_0002);
        do_rd("btn_edge_clr", 32'h0000_004C, 32'd0);
        Button = 2'b00;
        repeat (25) @(negedge CLK_50);
        do_rd("btn_rel_lvl", 32'h0000_0048, 32'd0);
        do_rd("btn_fall_edge", 32'h0000_004C, 32'd0);
        // Clear lands in Q503 exactly when the debounced rise is accepted
        Button = 2'b10;
        repeat (DEB) @(negedge CLK_50);
        do_wr("btn_coinc_wr", 32'h0000_004C, 32'h0000_0002);
        do_rd("btn_coinc", 32'h0000_004C, 32'h0000_0002);
        Button = 2'b00;

        // Cycle counter wrap and write-ignore
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt_q;
        req(RD, 32'h0000_0050, 32'd0);
        req(RD, 32'h0000_0050, 32'd0);
        req(WR, 32'h0000_0050, 32'h1234_5678);
        req(RD, 32'h0000_0050, 32'd0);
        get_rsp("cnt0", r);
        chk("cnt_pre_wrap", 64'(r.data), 64'hFFFF_FFFF);
        get_rsp("cnt1", r);
        chk("cnt_wrap", 64'(r.data), 64'd0);
        get_rsp("cnt2", r);
        chk("cnt_wr_data", 64'(r.data), 64'd0);
        get_rsp("cnt3", r);
        chk("cnt_after_wr", 64'(r.data), 64'd2);

`ifdef FPGA_MMIO_HEX_DECODE_EN
        do_wr("hex_ctrl_wr", 32'h0000_005C, 32'h0000_0001);
        do_wr("hex_val_wr", 32'h0000_0058, 32'h0000_0008);
        chk("hex_digit0", 64'(SEG7[6:0]), 64'h00);
        chk("hex_digit1", 64'(SEG7[13:7]), 64'h40);
        do_rd("hex_ctrl_rd", 32'h0000_005C, 32'h0000_0001);
        do_wr("hex_ctrl_off", 32'h0000_005C, 32'h0000_0000);
        chk("hex_off_digit0", 64'(SEG7[6:0]), 64'h12);
`else
        do_rd("hex_unmapped", 32'h0000_0058, 32'd0);
        do_rd("ctrl_unmapped", 32'h0000_005C, 32'd0);
`endif

        // Reset with a read in flight: no response, outputs back to reset values
        req(RD, 32'h0000_0040, 32'd0);
        RstQnnnL = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_50);
            chk("midrst_vld", 64'(F2C_RspValidQ500H), 64'd0);
        end
        chk("midrst_seg7", 64'(SEG7), 64'h3FF_FFFF_FFFF);
        chk("midrst_led", 64'(LED), 64'd0);
        RstQnnnL = 1'b1;
        repeat (6) @(negedge CLK_50);
        chk("midrst_no_rsp", 64'(rsp_q.size()), 64'd0);
        req_cyc_q.delete();
        do_rd("post_rst_led", 32'h0000_0040, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
